m_controller: RTL and testbench
===============================

Name: m_controller

Overview:
Multi-cycle MIPS control unit sitting directly upstream of the multi-cycle datapath. It is a Moore FSM that decodes the latched instruction (Inst), datapath zero and memory MIO_ready, and drives every datapath control input plus memory-side strobes. One instruction completes per 3–5 cycles, plus memory wait cycles.

Parameters:
STATE_W, 5, width of state register / debug state output

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
MIO_ready  input  1  memory/IO ready; 0 stalls fetch and load
Inst  input  32  instruction register contents from datapath
zero  input  1  ALU zero flag from datapath
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
IRWrite  output  1  instruction register load
RegDst  output  2  00 rt, 01 rd, 10 $31
RegWrite  output  1  register file write
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 LUI, 11 PC
ALUSrcA  output  1  0 PC, 1 rs
ALUSrcB  output  2  00 rt, 01 4, 10 sign-ext imm, 11 imm<<2
PCSource  output  2  00 ALU res, 01 ALUOut, 10 jump target, 11 ALUOut
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  conditional PC write
Branch  output  1  1 = beq (take on zero), 0 = bne
ALU_operation  output  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT
mem_w  output  1  memory write strobe
CPU_MIO  output  1  memory access request
state  output  STATE_W  current state, debug
illegal_inst  output  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- Outputs are pure decodes of the state register. Any signal not listed for a state is 0, and ALU_operation defaults to ADD.
- reset=0 forces state=IF asynchronously. Reset outputs equal the IF decode.
- Reset mid-instruction aborts it; no RegWrite or mem_w is asserted after reset.
- Supported: R-type add/sub/and/or/xor/nor/slt/jr; addi, andi, ori, xori, slti, lui, lw, sw, beq, bne, j, jal.
- IF: CPU_MIO=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWrite=1.
  - Stays in IF while MIO_ready=0; the datapath gates the PC write.
  - Goes to ID when MIO_ready=1.
- ID: ALUSrcA=0, ALUSrcB=11, ADD; ALUOut captures the branch target. Next state by opcode:
  - R: funct 001000 → JR, else EX_R
  - lw/sw → MEM_ADDR
  - beq/bne → BRANCH
  - I-arith → EX_I
  - lui → LUI_WB
  - j → JUMP
  - jal → JAL
  - other → ILLEGAL
- EX_R: ALUSrcA=1, ALUSrcB=00, op from funct. Unknown funct → ILLEGAL from ID instead. Next R_WB.
- R_WB: RegDst=01, MemtoReg=00, RegWrite=1 → IF.
- EX_I: ALUSrcA=1, ALUSrcB=10; addi ADD, andi AND, ori OR, xori XOR, slti SLT → I_WB.
- I_WB: RegDst=00, MemtoReg=00, RegWrite=1 → IF.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: CPU_MIO=1, IorD=1. Waits while MIO_ready=0, then → MEM_WB.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1 → IF.
- MEM_WR: CPU_MIO=1, IorD=1, mem_w=1. Held until MIO_ready=1 → IF.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWriteCond=1, Branch=(opcode==beq) → IF.
- JUMP: PCSource=10, PCWrite=1 → IF.
- JAL: RegDst=10, MemtoReg=11, RegWrite=1, PCSource=10, PCWrite=1 → IF. $31 receives the PC before the update, i.e. PC+4.
- JR: ALUSrcA=1, ALUSrcB=00, ADD (rt=0), PCSource=00, PCWrite=1 → IF.
- LUI_WB: RegDst=00, MemtoReg=10, RegWrite=1 → IF.
- ILLEGAL: illegal_inst=1, no writes → IF; the PC has already advanced.
- Cycle counts with MIO_ready=1:
  - 3 cycles: beq/bne, j, jal, jr, lui
  - 4 cycles: R, I-arith, sw
  - 5 cycles: lw
- Unused state encodings → IF on the next clock.

Test Plan:
- reset=0 asserted mid-EX_R, then released → state=IF, IRWrite=1, PCWrite=1, RegWrite never pulses.
- add $3,$1,$2 (0x00221820), MIO_ready=1 → states IF,ID,EX_R,R_WB; R_WB drives RegDst=01, RegWrite=1, ALU_operation=0010 in EX_R.
- lw $4,8($1) with MIO_ready low 2 cycles in IF and 3 cycles in MEM_RD → 10 total cycles; RegWrite high exactly 1 cycle with MemtoReg=01.
- beq with zero=1 and bne with zero=1 → BRANCH asserts PCWriteCond=1, Branch=1 and Branch=0 respectively, PCSource=01.
- jal 0x0000040 → JAL: RegDst=10, MemtoReg=11, PCSource=10, PCWrite=1; jr $31 (0x03E00008) → JR: PCSource=00, ALUSrcA=1.
- opcode 0x3F → ILLEGAL: illegal_inst one-cycle pulse, no RegWrite or mem_w; the next state is IF.

Source files
------------

// File: rtl/m_controller.sv
// Multi-cycle MIPS control unit: Moore FSM decoding the latched instruction into
// datapath controls. Outputs are registered from the next-state decode.
module m_controller #(
    parameter int STATE_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               MIO_ready,
    input  logic [31:0]        Inst,
    input  logic               zero,
    output logic               IorD,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               Branch,
    output logic [3:0]         ALU_operation,
    output logic               mem_w,
    output logic               CPU_MIO,
    output logic [STATE_W-1:0] state,
    output logic               illegal_inst
);

    // Debug state encoding: IF=0 ID=1 EX_R=2 R_WB=3 EX_I=4 I_WB=5 MEM_ADDR=6 MEM_RD=7
    // MEM_WB=8 MEM_WR=9 BRANCH=10 JUMP=11 JAL=12 JR=13 LUI_WB=14 ILLEGAL=15
    typedef enum logic [STATE_W-1:0] {
        S_IF, S_ID, S_EX_R, S_R_WB, S_EX_I, S_I_WB, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_LUI_WB, S_ILLEGAL
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic [1:0] regdst;
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch;
        logic [3:0] alu_op;
        logic       mem_w;
        logic       cpu_mio;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [5:0] opcode;
    logic [5:0] funct;
    state_t     state_q, state_d;
    ctrl_t      ctrl_q;

    assign opcode = Inst[31:26];
    assign funct  = Inst[5:0];

    // Register fields and the zero flag are consumed by the datapath only.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, zero, Inst[25:6]};

    // Returns {valid, alu_op} for an R-type arithmetic funct.
    function automatic logic [4:0] r_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: r_decode = {1'b1, ALU_ADD};
            6'b100010: r_decode = {1'b1, ALU_SUB};
            6'b100100: r_decode = {1'b1, ALU_AND};
            6'b100101: r_decode = {1'b1, ALU_OR};
            6'b100110: r_decode = {1'b1, ALU_XOR};
            6'b100111: r_decode = {1'b1, ALU_NOR};
            6'b101010: r_decode = {1'b1, ALU_SLT};
            default:   r_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic logic [3:0] i_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: i_alu_op = ALU_AND;
            OP_ORI:  i_alu_op = ALU_OR;
            OP_XORI: i_alu_op = ALU_XOR;
            OP_SLTI: i_alu_op = ALU_SLT;
            default: i_alu_op = ALU_ADD;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [5:0] op,
                                     input logic [5:0] fn);
        ctrl_t     c;
        logic [4:0] rd;
        c        = '0;
        c.alu_op = ALU_ADD;
        rd       = r_decode(fn);
        case (s)
            S_IF: begin
                c.cpu_mio = 1'b1;
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
            end
            S_ID:       c.alusrcb = 2'b11;
            S_EX_R: begin
                c.alusrca = 1'b1;
                c.alu_op  = rd[3:0];
            end
            S_R_WB: begin
                c.regdst   = 2'b01;
                c.regwrite = 1'b1;
            end
            S_EX_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.alu_op  = i_alu_op(op);
            end
            S_I_WB:     c.regwrite = 1'b1;
            S_MEM_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEM_RD: begin
                c.cpu_mio = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WB: begin
                c.memtoreg = 2'b01;
                c.regwrite = 1'b1;
            end
            S_MEM_WR: begin
                c.cpu_mio = 1'b1;
                c.iord    = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alu_op      = ALU_SUB;
                c.pcsource    = 2'b01;
                c.pcwritecond = 1'b1;
                c.branch      = (op == OP_BEQ);
            end
            S_JUMP: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
            // $31 takes the PC before this cycle's update, which is already PC+4.
            S_JAL: begin
                c.regdst   = 2'b10;
                c.memtoreg = 2'b11;
                c.regwrite = 1'b1;
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
            S_JR: begin
                c.alusrca = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_LUI_WB: begin
                c.memtoreg = 2'b10;
                c.regwrite = 1'b1;
            end
            S_ILLEGAL:  c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR)     state_d = S_JR;
                        else if (r_decode(funct) >= 5'h10) state_d = S_EX_R;
                        else                    state_d = S_ILLEGAL;
                    end
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EX_I;
                    OP_LUI:         state_d = S_LUI_WB;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_EX_R:     state_d = S_R_WB;
            S_EX_I:     state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = MIO_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = MIO_ready ? S_IF : S_MEM_WR;
            default:    state_d = S_IF;
        endcase
    end

    // Outputs are registered alongside the state so they are glitch-free decodes of it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            ctrl_q  <= decode(S_IF, 6'b0, 6'b0);
        end else begin
            // NOTE: non-blocking so state and outputs update together from pre-edge values.
            state_q <= state_d;
            ctrl_q  <= decode(state_d, opcode, funct);
        end
    end

    assign IorD          = ctrl_q.iord;
    assign IRWrite       = ctrl_q.irwrite;
    assign RegDst        = ctrl_q.regdst;
    assign RegWrite      = ctrl_q.regwrite;
    assign MemtoReg      = ctrl_q.memtoreg;
    assign ALUSrcA       = ctrl_q.alusrca;
    assign ALUSrcB       = ctrl_q.alusrcb;
    assign PCSource      = ctrl_q.pcsource;
    assign PCWrite       = ctrl_q.pcwrite;
    assign PCWriteCond   = ctrl_q.pcwritecond;
    assign Branch        = ctrl_q.branch;
    assign ALU_operation = ctrl_q.alu_op;
    assign mem_w         = ctrl_q.mem_w;
    assign CPU_MIO       = ctrl_q.cpu_mio;
    assign illegal_inst  = ctrl_q.illegal;
    assign state         = state_q;

endmodule

// File: tb/tb_m_controller.sv
// Self-checking bench for m_controller: directed vector table, reset abort sequence
// and randomized instruction streams checked against a per-instruction state-walk model.
module tb_m_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        MIO_ready;
    logic [31:0] Inst;
    logic        zero;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
    logic        mem_w, CPU_MIO, illegal_inst;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [3:0]  ALU_operation;
    logic [4:0]  state;

    m_controller #(.STATE_W(5)) dut (
        .clock(clock), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .ALU_operation(ALU_operation), .mem_w(mem_w), .CPU_MIO(CPU_MIO),
        .state(state), .illegal_inst(illegal_inst)
    );

    always #5 clock = ~clock;

    localparam int IF = 0, ID = 1, EX_R = 2, R_WB = 3, EX_I = 4, I_WB = 5, MEM_ADDR = 6;
    localparam int MEM_RD = 7, MEM_WB = 8, MEM_WR = 9, BRANCH = 10, JUMP = 11, JAL = 12;
    localparam int JR = 13, LUI_WB = 14, ILLEGAL = 15;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic [1:0] regdst;
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch;
        logic [3:0] alu;
        logic       memw;
        logic       mio;
        logic       ill;
    } ctrl_t;

    ctrl_t act;
    assign act = {IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
                  PCWrite, PCWriteCond, Branch, ALU_operation, mem_w, CPU_MIO, illegal_inst};

    typedef struct { int st; bit mio; } step_t;
    typedef struct {
        logic [31:0] inst; bit z; int ifs; int mems; int cyc; int rw; int mw; int il;
    } vec_t;

    step_t seq[$];
    vec_t  tbl[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // ALU code for a supported R-type funct; 4'hF marks an unsupported one.
    function automatic logic [3:0] r_op(input logic [5:0] f);
        case (f)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b0100;
            6'h2A: return 4'b0111;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] i_op(input logic [5:0] op);
        case (op)
            6'h0C: return 4'b0000;
            6'h0D: return 4'b0001;
            6'h0E: return 4'b0011;
            6'h0A: return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected control word for a named state, straight from the per-state table.
    function automatic ctrl_t exp_ctrl(input int st, input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        c.alu = 4'b0010;
        case (st)
            IF:       begin c.mio = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1; end
            ID:       c.alusrcb = 2'b11;
            EX_R:     begin c.alusrca = 1; c.alu = r_op(ins[5:0]); end
            R_WB:     begin c.regdst = 2'b01; c.regwrite = 1; end
            EX_I:     begin c.alusrca = 1; c.alusrcb = 2'b10; c.alu = i_op(ins[31:26]); end
            I_WB:     c.regwrite = 1;
            MEM_ADDR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEM_RD:   begin c.mio = 1; c.iord = 1; end
            MEM_WB:   begin c.memtoreg = 2'b01; c.regwrite = 1; end
            MEM_WR:   begin c.mio = 1; c.iord = 1; c.memw = 1; end
            BRANCH:   begin c.alusrca = 1; c.alu = 4'b0110; c.pcsource = 2'b01;
                            c.pcwritecond = 1; c.branch = (ins[31:26] == 6'h04); end
            JUMP:     begin c.pcsource = 2'b10; c.pcwrite = 1; end
            JAL:      begin c.regdst = 2'b10; c.memtoreg = 2'b11; c.regwrite = 1;
                            c.pcsource = 2'b10; c.pcwrite = 1; end
            JR:       begin c.alusrca = 1; c.pcwrite = 1; end
            LUI_WB:   begin c.memtoreg = 2'b10; c.regwrite = 1; end
            ILLEGAL:  c.ill = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    // Builds the state walk of one instruction, with MIO_ready per cycle.
    task automatic build_seq(input logic [31:0] ins, input int ifs, input int mems);
        logic [5:0] op;
        op = ins[31:26];
        seq.delete();
        for (int i = 0; i < ifs; i++) seq.push_back('{IF, 1'b0});
        seq.push_back('{IF, 1'b1});
        seq.push_back('{ID, rnd_bit()});
        case (op)
            6'h00: begin
                if (ins[5:0] == 6'h08) seq.push_back('{JR, rnd_bit()});
                else if (r_op(ins[5:0]) != 4'hF) begin
                    seq.push_back('{EX_R, rnd_bit()});
                    seq.push_back('{R_WB, rnd_bit()});
                end else seq.push_back('{ILLEGAL, rnd_bit()});
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                seq.push_back('{EX_I, rnd_bit()});
                seq.push_back('{I_WB, rnd_bit()});
            end
            6'h0F: seq.push_back('{LUI_WB, rnd_bit()});
            6'h23: begin
                seq.push_back('{MEM_ADDR, rnd_bit()});
                for (int i = 0; i < mems; i++) seq.push_back('{MEM_RD, 1'b0});
                seq.push_back('{MEM_RD, 1'b1});
                seq.push_back('{MEM_WB, rnd_bit()});
            end
            6'h2B: begin
                seq.push_back('{MEM_ADDR, rnd_bit()});
                for (int i = 0; i < mems; i++) seq.push_back('{MEM_WR, 1'b0});
                seq.push_back('{MEM_WR, 1'b1});
            end
            6'h04, 6'h05: seq.push_back('{BRANCH, rnd_bit()});
            6'h02: seq.push_back('{JUMP, rnd_bit()});
            6'h03: seq.push_back('{JAL, rnd_bit()});
            default: seq.push_back('{ILLEGAL, rnd_bit()});
        endcase
    endtask

    // Called and returns at a falling edge with the DUT expected in IF.
    task automatic run_instr(input logic [31:0] ins, input bit z, input int ifs, input int mems,
                             output int cyc, output int rw, output int mw, output int il);
        bit left_if, done;
        left_if = 0; done = 0; cyc = 0; rw = 0; mw = 0; il = 0;
        Inst = ins;
        zero = z;
        build_seq(ins, ifs, mems);
        foreach (seq[i]) begin
            check($sformatf("state step %0d inst %h", i, ins), 32'(state), seq[i].st);
            check($sformatf("ctrl step %0d inst %h", i, ins), 32'(act),
                  32'(exp_ctrl(seq[i].st, ins)));
            rw += int'(RegWrite);
            mw += int'(mem_w);
            il += int'(illegal_inst);
            if (!done) begin
                if (state != 5'(IF)) left_if = 1;
                else if (left_if) done = 1;
                if (!done) cyc++;
            end
            MIO_ready = seq[i].mio;
            @(negedge clock);
        end
        check($sformatf("back to IF inst %h", ins), 32'(state), IF);
        if (!(done || (left_if && state == 5'(IF)))) cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int cyc, rw, mw, il;
        logic [5:0] ops [17];
        logic [5:0] fns [9];
        logic [31:0] ins;

        reset = 1'b0; MIO_ready = 1'b0; Inst = '0; zero = 1'b0;
        repeat (2) @(negedge clock);
        check("reset state", 32'(state), IF);
        check("reset ctrl", 32'(act), 32'(exp_ctrl(IF, 32'h0)));
        reset = 1'b1;

        // Abort an add in EX_R: reset must land in IF asynchronously and suppress R_WB.
        Inst = 32'h00221820; MIO_ready = 1'b1;
        @(negedge clock);
        check("abort ID", 32'(state), ID);
        @(negedge clock);
        check("abort EX_R", 32'(state), EX_R);
        check("abort EX_R alu", 32'(ALU_operation), 32'h2);
        reset = 1'b0;
        #1;
        check("async reset state", 32'(state), IF);
        check("async reset IRWrite", 32'(IRWrite), 1);
        check("async reset PCWrite", 32'(PCWrite), 1);
        check("async reset RegWrite", 32'(RegWrite), 0);
        MIO_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post reset RegWrite %0d", i), 32'(RegWrite), 0);
            check($sformatf("post reset state %0d", i), 32'(state), IF);
            @(negedge clock);
        end

        tbl.push_back('{32'h00221820, 0, 0, 0, 4, 1, 0, 0});  // add
        tbl.push_back('{32'h8C240008, 0, 2, 3, 10, 1, 0, 0}); // lw with stalls
        tbl.push_back('{32'h10220004, 1, 0, 0, 3, 0, 0, 0});  // beq
        tbl.push_back('{32'h14220004, 1, 0, 0, 3, 0, 0, 0});  // bne
        tbl.push_back('{32'h0C000010, 0, 0, 0, 3, 1, 0, 0});  // jal 0x40
        tbl.push_back('{32'h03E00008, 0, 0, 0, 3, 0, 0, 0});  // jr $31
        tbl.push_back('{32'h3C051234, 0, 0, 0, 3, 1, 0, 0});  // lui
        tbl.push_back('{32'h20220005, 0, 1, 0, 5, 1, 0, 0});  // addi, 1 fetch stall
        tbl.push_back('{32'hAC24000C, 0, 0, 1, 5, 0, 2, 0});  // sw, 1 write stall
        tbl.push_back('{32'h08000010, 0, 0, 0, 3, 0, 0, 0});  // j
        tbl.push_back('{32'h342300FF, 0, 0, 0, 4, 1, 0, 0});  // ori
        tbl.push_back('{32'h0022182A, 0, 0, 0, 4, 1, 0, 0});  // slt
        tbl.push_back('{32'h8C240008, 0, 0, 0, 5, 1, 0, 0});  // lw no stall
        tbl.push_back('{32'hFC000000, 0, 0, 0, 3, 0, 0, 1});  // opcode 0x3F
        tbl.push_back('{32'h0000003F, 0, 0, 0, 3, 0, 0, 1});  // bad funct

        MIO_ready = 1'b1;
        foreach (tbl[k]) begin
            run_instr(tbl[k].inst, tbl[k].z, tbl[k].ifs, tbl[k].mems, cyc, rw, mw, il);
            check($sformatf("cycles inst %h", tbl[k].inst), 32'(cyc), 32'(tbl[k].cyc));
            check($sformatf("RegWrite count inst %h", tbl[k].inst), 32'(rw), 32'(tbl[k].rw));
            check($sformatf("mem_w count inst %h", tbl[k].inst), 32'(mw), 32'(tbl[k].mw));
            check($sformatf("illegal count inst %h", tbl[k].inst), 32'(il), 32'(tbl[k].il));
        end

        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h01};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h3F};
        for (int n = 0; n < 200; n++) begin
            ins = {ops[$urandom_range(0, 16)], 26'($urandom)};
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 8)];
            run_instr(ins, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3),
                      cyc, rw, mw, il);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
